// File: rtl/instruction_fetch_unit.sv
// Decoupled fetch stage: owns the PC, issues 1-cycle-latency imem reads and
// queues {instr, pc} pairs for decode; redirects flush all younger work.
module instruction_fetch_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int IMEM_DEPTH = 256,
  parameter int FIFO_DEPTH = 2,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = '0,
  localparam int AW = $clog2(IMEM_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_enable,
  output logic                  imem_req,
  output logic [AW-1:0]         imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  input  logic [1:0]            redirect_kind,
  input  logic [DATA_WIDTH-1:0] redirect_base_pc,
  input  logic [DATA_WIDTH-1:0] redirect_imm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [DATA_WIDTH-1:0] out_pc
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = CW + 1;

  logic [DATA_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_req_pc;
  logic                  r_inflight;
  logic                  r_kill;
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_wr_ptr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_instr_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_pc_q    [FIFO_DEPTH];

  logic                  w_redirect;
  logic                  w_pop;
  logic                  w_push_en;
  logic [OW-1:0]         w_occ;
  logic [DATA_WIDTH-1:0] w_seq_pc;
  logic [DATA_WIDTH-1:0] w_target;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_redirect = (redirect_kind != 2'b00);
  assign out_valid  = (r_count != '0) & ~w_redirect & ~reset;
  assign w_pop      = out_valid & out_ready;
  // A dead response still occupies the slot it was issued into, but it is never written.
  assign w_push_en  = r_inflight & ~r_kill & ~w_redirect;

  // Credit check counts the in-flight word and frees the slot being popped now.
  assign w_occ    = {1'b0, r_count} + OW'(r_inflight) - OW'(w_pop);
  assign imem_req = fetch_enable & ~reset & ~w_redirect & (w_occ < OW'(FIFO_DEPTH));
  assign imem_addr = r_pc[AW+1:2];

  assign out_instr = (r_count != '0) ? r_instr_q[r_rd_ptr] : '0;
  assign out_pc    = (r_count != '0) ? r_pc_q[r_rd_ptr]    : '0;

  always_comb begin
    w_seq_pc = redirect_base_pc + DATA_WIDTH'(4);
    w_target = r_pc;
    case (redirect_kind)
      2'b01: w_target = w_seq_pc + (redirect_imm << 2);
      2'b10: begin
        w_target       = w_seq_pc;
        w_target[27:0] = {redirect_imm[25:0], 2'b00};
      end
      2'b11: w_target = {redirect_imm[DATA_WIDTH-1:2], 2'b00};
      default: w_target = r_pc;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_req_pc   <= '0;
      r_inflight <= 1'b0;
      r_kill     <= 1'b0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= imem_req;
      if (w_redirect) begin
        r_pc     <= w_target;
        r_kill   <= r_inflight;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        r_kill <= 1'b0;
        if (imem_req) begin
          r_pc     <= r_pc + DATA_WIDTH'(4);
          r_req_pc <= r_pc;
        end
        if (w_push_en) r_wr_ptr <= f_inc(r_wr_ptr);
        if (w_pop)     r_rd_ptr <= f_inc(r_rd_ptr);
        if (w_push_en && !w_pop)      r_count <= r_count + 1'b1;
        else if (!w_push_en && w_pop) r_count <= r_count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push_en) begin
      r_instr_q[r_wr_ptr] <= imem_rdata;
      r_pc_q[r_wr_ptr]    <= r_req_pc;
    end
  end

  assert property (@(posedge clk) disable iff (reset)
    !(w_push_en && !w_pop && (r_count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus random traffic,
// compared each cycle against a queue-based reference model.
module tb_instruction_fetch_unit;

  localparam int DW = 32;
  localparam int DEPTH = 256;
  localparam int FD = 2;
  localparam int AW = 8;

  logic          clk;
  logic          reset;
  logic          fetch_enable;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata;
  logic [1:0]    redirect_kind;
  logic [DW-1:0] redirect_base_pc;
  logic [DW-1:0] redirect_imm;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_instr;
  logic [DW-1:0] out_pc;

  instruction_fetch_unit #(
    .DATA_WIDTH(DW), .IMEM_DEPTH(DEPTH), .FIFO_DEPTH(FD), .RESET_PC('0)
  ) dut (
    .clk(clk), .reset(reset), .fetch_enable(fetch_enable),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_kind(redirect_kind), .redirect_base_pc(redirect_base_pc),
    .redirect_imm(redirect_imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000_0000 + i;
    imem_rdata = '0;
  end
  always @(posedge clk) if (imem_req) imem_rdata <= mem[imem_addr];

  int n_chk;
  int n_err;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: PC, outstanding read, kill flag and a queue of pending outputs.
  logic [DW-1:0] m_pc;
  logic [DW-1:0] m_ipc;
  bit            m_inflight;
  bit            m_kill;
  logic [DW-1:0] mq_pc[$];
  logic [DW-1:0] mq_instr[$];

  function automatic logic [DW-1:0] memword(input logic [DW-1:0] pc);
    return 32'h1000_0000 + ((pc >> 2) % DEPTH);
  endfunction

  function automatic logic [DW-1:0] target(input logic [1:0] kind, input logic [DW-1:0] base,
                                           input logic [DW-1:0] imm);
    logic [DW-1:0] seq;
    seq = base + 4;
    case (kind)
      2'd1:    return seq + imm * 4;
      2'd2:    return (seq & 32'hF000_0000) | ((imm & 32'h03FF_FFFF) * 4);
      default: return imm & 32'hFFFF_FFFC;
    endcase
  endfunction

  task automatic model_clear();
    m_pc = '0;
    m_ipc = '0;
    m_inflight = 0;
    m_kill = 0;
    mq_pc.delete();
    mq_instr.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_instr", out_instr, 0);
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic step(input bit en, input bit rdy, input logic [1:0] kind,
                      input logic [DW-1:0] base, input logic [DW-1:0] imm);
    bit mv, mp, mr;
    int occ;
    fetch_enable = en;
    out_ready = rdy;
    redirect_kind = kind;
    redirect_base_pc = base;
    redirect_imm = imm;
    #2;
    mv = (mq_pc.size() != 0) && (kind == 0);
    mp = mv && rdy;
    occ = mq_pc.size() + (m_inflight ? 1 : 0) - (mp ? 1 : 0);
    mr = en && (kind == 0) && (occ < FD);
    chk("valid", out_valid, mv);
    chk("req", imem_req, mr);
    if (mr) chk("addr", imem_addr, (m_pc >> 2) % DEPTH);
    if (mq_pc.size() != 0) begin
      chk("out_pc", out_pc, mq_pc[0]);
      chk("out_instr", out_instr, mq_instr[0]);
    end else begin
      chk("empty_pc", out_pc, 0);
      chk("empty_instr", out_instr, 0);
    end
    @(posedge clk);
    if (kind != 0) begin
      m_pc = target(kind, base, imm);
      mq_pc.delete();
      mq_instr.delete();
      m_kill = m_inflight;
      m_inflight = 0;
    end else begin
      if (mp) begin
        void'(mq_pc.pop_front());
        void'(mq_instr.pop_front());
      end
      if (m_inflight && !m_kill) begin
        mq_pc.push_back(m_ipc);
        mq_instr.push_back(memword(m_ipc));
      end
      m_kill = 0;
      m_inflight = mr;
      if (mr) begin
        m_ipc = m_pc;
        m_pc = m_pc + 4;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    fetch_enable = 1'b1;
    out_ready = 1'b1;
    redirect_kind = 2'b00;
    redirect_base_pc = '0;
    redirect_imm = '0;
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    fetch_enable = 0;
    out_ready = 0;
    redirect_kind = 0;
    redirect_base_pc = 0;
    redirect_imm = 0;
    model_clear();
    do_reset();

    // Streaming from reset; first output two cycles after release.
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("first_valid", out_valid, 1);
    chk("first_pc", out_pc, 32'h0);
    chk("first_instr", out_instr, 32'h1000_0000);
    repeat (6) step(1, 1, 0, 0, 0);

    // Backpressure then release.
    repeat (5) step(1, 0, 0, 0, 0);
    chk("bp_req_low", imem_req, 0);
    repeat (6) step(1, 1, 0, 0, 0);

    // Branch with a read in flight: target 0x08, visible three cycles later.
    step(1, 1, 2'd1, 32'h10, 32'hFFFF_FFFD);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    #1;
    chk("br_valid", out_valid, 1);
    chk("br_pc", out_pc, 32'h8);
    chk("br_instr", out_instr, 32'h1000_0002);
    repeat (3) step(1, 1, 0, 0, 0);

    // Jump into high region, word index wraps to 0x40.
    step(1, 1, 2'd2, 32'hF000_0000, 32'h0000_0040);
    idle_inputs();
    chk("jmp_req", imem_req, 1);
    chk("jmp_addr", imem_addr, 8'h40);
    repeat (4) step(1, 1, 0, 0, 0);

    // Absolute redirect with a full, stalled queue.
    repeat (4) step(1, 0, 0, 0, 0);
    chk("abs_full", dut.r_count, FD);
    step(1, 0, 2'd3, 0, 32'h0000_0206);
    idle_inputs();
    chk("abs_flushed", out_valid, 0);
    chk("abs_addr", imem_addr, 8'h81);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    #1;
    chk("abs_pc", out_pc, 32'h204);
    chk("abs_instr", out_instr, 32'h1000_0081);

    // Redirect while fetch is disabled, then resume.
    step(0, 1, 2'd3, 0, 32'h0000_0100);
    repeat (3) step(0, 1, 0, 0, 0);
    repeat (4) step(1, 1, 0, 0, 0);

    // Reset mid-stream.
    repeat (3) step(1, 0, 0, 0, 0);
    do_reset();
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    #1;
    chk("rst_first_pc", out_pc, 32'h0);
    chk("rst_first_valid", out_valid, 1);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      bit en, rdy;
      logic [1:0] kind;
      logic [DW-1:0] base, imm;
      en = ($urandom_range(0, 7) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      kind = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      base = $urandom() & 32'hFFFF_FFFC;
      imm = $urandom();
      if ($urandom_range(0, 399) == 0) do_reset();
      else step(en, rdy, kind, base, imm);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
